// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core.
// Instruction port: word memory with combinational fetch and a preload path.
// Data port: word RAM plus a 16-byte MMIO window (cycle counter, tohost,
// scratch). An optional wait-state FSM delays each access and signals
// completion through data_ready. Access errors are sticky in err.
module mips_mem_responder #(
  parameter logic [31:0] INSTR_BASE  = 32'h1000,
  parameter int          INSTR_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h0,
  parameter int          DATA_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data,
  output logic        data_ready,
  output logic        err,
  output logic        halt,
  output logic [31:0] tohost,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int          IAW     = $clog2(INSTR_WORDS);
  localparam int          DAW     = $clog2(DATA_WORDS);
  localparam logic [31:0] HALT_OP = 32'hFC00_0000;

  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];

  logic [31:0] cycleCnt;
  logic [31:0] scratch;

  // Instruction fetch decode; addresses below the base wrap to huge indices
  // and therefore fall out of range.
  logic [31:0] iOff, iIdx;
  logic        iOk;
  assign iOff  = instr_addr - INSTR_BASE;
  assign iIdx  = iOff >> 2;
  assign iOk   = (iOff[1:0] == 2'b00) && (iIdx < 32'(INSTR_WORDS));
  assign instr = iOk ? imem[iIdx[IAW-1:0]] : HALT_OP;

  // Preload decode uses the same mapping as fetch.
  logic [31:0] lOff, lIdx;
  logic        lOk;
  assign lOff = load_addr - INSTR_BASE;
  assign lIdx = lOff >> 2;
  assign lOk  = (lOff[1:0] == 2'b00) && (lIdx < 32'(INSTR_WORDS));

  // Preload writes into instruction memory; out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (load_en && lOk) imem[lIdx[IAW-1:0]] <= load_data;
  end

  // Access being decoded: the live bus with no wait states, otherwise the
  // request latched by the FSM.
  logic [31:0] accAddr;
  logic [31:0] wrDat;
  logic        accRd, accWr, accFire;

  logic [31:0] dOff, dIdx;
  logic        inData, inMmio, misal, addrOk;
  assign dOff   = accAddr - DATA_BASE;
  assign dIdx   = dOff >> 2;
  assign inData = dIdx < 32'(DATA_WORDS);
  assign inMmio = accAddr[31:4] == MMIO_BASE[31:4];
  assign misal  = accAddr[1:0] != 2'b00;
  assign addrOk = !misal && (inData || inMmio);

  // Read mux over RAM and MMIO; illegal addresses read as zero.
  logic [31:0] rdVal;
  always_comb begin
    rdVal = '0;
    if (addrOk) begin
      if (inData) begin
        rdVal = dmem[dIdx[DAW-1:0]];
      end else begin
        case (accAddr[3:2])
          2'd0:    rdVal = cycleCnt;
          2'd1:    rdVal = tohost;
          2'd2:    rdVal = scratch;
          default: rdVal = '0;
        endcase
      end
    end
  end

  // A completing access is an error if its address is bad or it asks for
  // both a read and a write; only clean writes commit.
  logic accErr, wrFire;
  assign accErr = accFire && (!addrOk || (accRd && accWr));
  assign wrFire = accFire && accWr && !accRd && addrOk;

  // Data RAM write port, no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wrFire && inData) dmem[dIdx[DAW-1:0]] <= wrDat;
  end

  // Status and MMIO registers: counter, sticky err/halt, tohost, scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt <= '0;
      scratch  <= '0;
      tohost   <= '0;
      halt     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (!iOk || accErr) err <= 1'b1;
      if (wrFire && !inData && inMmio) begin
        case (accAddr[3:2])
          2'd1: begin
            tohost <= wrDat;
            halt   <= 1'b1;
          end
          2'd2:    scratch <= wrDat;
          default: ;
        endcase
      end
    end
  end

  generate
    if (WAIT_STATES == 0) begin : gZeroWait
      assign accAddr    = data_addr;
      assign wrDat      = data_in;
      assign accRd      = mem_read;
      assign accWr      = mem_write;
      assign accFire    = (mem_read || mem_write) && !rst;
      assign data_ready = accFire;
      assign data       = (mem_read && !rst) ? rdVal : 32'd0;
    end else begin : gWaitFsm
      typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} stateT;
      stateT       state;
      logic [31:0] addrL, dataL, dataQ;
      logic        rdL, wrL, readyQ;
      logic [3:0]  cnt;

      // Latch the request, count wait states, then complete for one cycle;
      // a request dropped while waiting aborts without side effects.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= S_IDLE;
          addrL  <= '0;
          dataL  <= '0;
          rdL    <= 1'b0;
          wrL    <= 1'b0;
          cnt    <= '0;
          readyQ <= 1'b0;
          dataQ  <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              if (mem_read || mem_write) begin
                addrL <= data_addr;
                dataL <= data_in;
                rdL   <= mem_read;
                wrL   <= mem_write;
                cnt   <= 4'(WAIT_STATES);
                state <= S_WAIT;
              end
            end
            S_WAIT: begin
              if (!(mem_read || mem_write)) begin
                state <= S_IDLE;
              end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                  state  <= S_DONE;
                  readyQ <= 1'b1;
                  dataQ  <= rdL ? rdVal : 32'd0;
                end
              end
            end
            S_DONE: begin
              readyQ <= 1'b0;
              dataQ  <= '0;
              state  <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end

      assign accAddr    = addrL;
      assign wrDat      = dataL;
      assign accRd      = rdL;
      assign accWr      = wrL;
      assign accFire    = (state == S_DONE);
      assign data_ready = readyQ;
      assign data       = dataQ;
    end
  endgenerate

endmodule
